// File: rtl/uop_pkg.sv
// Shared uop definitions used by the issue queue and register_file_controller.
package uop_pkg;

    localparam int unsigned KIND_WIDTH     = 3;
    localparam int unsigned REGISTER_COUNT = 8;
    localparam int unsigned OPERAND1_WIDTH = $clog2(REGISTER_COUNT);
    localparam int unsigned OPERAND2_WIDTH = 4;

    localparam logic [KIND_WIDTH-1:0] KIND_NOP = '0;

    typedef struct packed {
        logic [KIND_WIDTH-1:0]     kind;
        logic [OPERAND1_WIDTH-1:0] operand1;
        logic [OPERAND2_WIDTH-1:0] operand2;
    } uop_t;

endpackage

// File: rtl/uop_issue_queue.sv
// In-order uop FIFO with NOP drop on entry, flush, and a per-pop sequence number.
module uop_issue_queue
    import uop_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned REGISTER_COUNT = uop_pkg::REGISTER_COUNT,
    parameter int unsigned KIND_WIDTH     = uop_pkg::KIND_WIDTH,
    parameter int unsigned OPERAND2_WIDTH = uop_pkg::OPERAND2_WIDTH,
    parameter int unsigned SEQ_WIDTH      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [KIND_WIDTH-1:0]             in_kind,
    input  logic [$clog2(REGISTER_COUNT)-1:0] in_operand1,
    input  logic [OPERAND2_WIDTH-1:0]         in_operand2,
    output logic                              out_valid,
    output logic [KIND_WIDTH-1:0]             out_kind,
    output logic [$clog2(REGISTER_COUNT)-1:0] out_operand1,
    output logic [OPERAND2_WIDTH-1:0]         out_operand2,
    output logic [SEQ_WIDTH-1:0]              out_seq,
    input  logic                              out_accepted,
    output logic [$clog2(DEPTH+1)-1:0]        count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [SEQ_WIDTH-1:0] seq_q, seq_d;
    uop_t                 mem_q [DEPTH];

    logic push;
    logic pop;
    uop_t in_uop;
    uop_t head_uop;

    // Handshake and head presentation; full/empty come from count, never from pointers.
    assign in_ready  = !rst && !flush && (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign out_seq   = seq_q;

    assign in_uop   = '{kind: in_kind, operand1: in_operand1, operand2: in_operand2};
    assign head_uop = mem_q[head_q];

    // Head fields read as zero while nothing is presented.
    always_comb begin
        out_kind     = '0;
        out_operand1 = '0;
        out_operand2 = '0;
        if (out_valid) begin
            out_kind     = head_uop.kind;
            out_operand1 = head_uop.operand1;
            out_operand2 = head_uop.operand2;
        end
    end

    // Next-state for pointers, occupancy and sequence counter; flush wins over push/pop.
    always_comb begin
        push    = in_valid && in_ready && (in_kind != KIND_NOP);
        pop     = out_valid && out_accepted;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        seq_d   = seq_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
                seq_d  = seq_q + SEQ_WIDTH'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            seq_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            seq_q   <= seq_d;
        end
    end

    // Storage writes; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= in_uop;
        end
    end

endmodule

// File: tb/tb_uop_issue_queue.sv
// Self-checking bench for uop_issue_queue: directed table, corner sequences, random vs. queue model.
module tb_uop_issue_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_kind;
    logic [2:0] in_operand1;
    logic [3:0] in_operand2;
    logic       out_valid;
    logic [2:0] out_kind;
    logic [2:0] out_operand1;
    logic [3:0] out_operand2;
    logic [3:0] out_seq;
    logic       out_accepted;
    logic [2:0] count;

    uop_issue_queue dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_kind      (in_kind),
        .in_operand1  (in_operand1),
        .in_operand2  (in_operand2),
        .out_valid    (out_valid),
        .out_kind     (out_kind),
        .out_operand1 (out_operand1),
        .out_operand2 (out_operand2),
        .out_seq      (out_seq),
        .out_accepted (out_accepted),
        .count        (count)
    );

    always #5 clk = ~clk;

    // Behavioural reference: a plain queue of uops plus a pop counter.
    typedef struct {
        int k;
        int a;
        int b;
    } muop_t;

    muop_t mq[$];
    int    pops;
    int    checks;
    int    errors;

    // Current cycle's stimulus, remembered for the model update at the edge.
    bit cur_r, cur_f, cur_v, cur_acc;
    int cur_k, cur_a, cur_b;

    typedef struct {
        bit f;
        bit v;
        int k;
        int a;
        int b;
        bit acc;
        int ec;
        bit ev;
        bit er;
        int ek;
        int es;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return !cur_r && !cur_f && (mq.size() != 4);
    endfunction

    // Drive one cycle's inputs after the falling edge, then compare against the model.
    task automatic apply(input bit r, input bit f, input bit v, input int k,
                         input int a, input int b, input bit acc);
        muop_t h;
        @(negedge clk);
        cur_r = r; cur_f = f; cur_v = v; cur_k = k; cur_a = a; cur_b = b; cur_acc = acc;
        rst          = r;
        flush        = f;
        in_valid     = v;
        in_kind      = 3'(k);
        in_operand1  = 3'(a);
        in_operand2  = 4'(b);
        out_accepted = acc;
        #1;
        h = '{k: 0, a: 0, b: 0};
        if (mq.size() != 0) h = mq[0];
        chk("count", int'(count), mq.size());
        chk("in_ready", int'(in_ready), int'(model_ready()));
        chk("out_seq", int'(out_seq), pops % 16);
        if (!r) begin
            chk("out_valid", int'(out_valid), int'(mq.size() != 0));
            chk("out_kind", int'(out_kind), h.k);
            chk("out_operand1", int'(out_operand1), h.a);
            chk("out_operand2", int'(out_operand2), h.b);
        end
    endtask

    // Advance through the rising edge and update the model from the same stimulus.
    task automatic tick();
        bit do_push, do_pop;
        do_push = cur_v && model_ready() && (cur_k != 0);
        do_pop  = (mq.size() != 0) && cur_acc;
        @(posedge clk);
        if (cur_r) begin
            mq.delete();
            pops = 0;
        end else if (cur_f) begin
            mq.delete();
        end else begin
            if (do_pop) begin
                void'(mq.pop_front());
                pops++;
            end
            if (do_push) mq.push_back('{k: cur_k, a: cur_a, b: cur_b});
        end
    endtask

    task automatic step(input bit r, input bit f, input bit v, input int k,
                        input int a, input int b, input bit acc);
        apply(r, f, v, k, a, b, acc);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pops   = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_kind = '0;
        in_operand1 = '0; in_operand2 = '0; out_accepted = 1'b0;

        // Fill, drain with concurrent push, flush with push+pop at count 3, NOP drop.
        //         f  v  k  a  b  acc  cnt v  r  kind seq
        vt[0]  = '{0, 1, 1, 0, 8,  0,  0, 0, 1, 0, 0};
        vt[1]  = '{0, 1, 2, 1, 9,  0,  1, 1, 1, 1, 0};
        vt[2]  = '{0, 1, 3, 2, 10, 0,  2, 1, 1, 1, 0};
        vt[3]  = '{0, 1, 4, 3, 11, 0,  3, 1, 1, 1, 0};
        vt[4]  = '{0, 1, 5, 4, 12, 0,  4, 1, 0, 1, 0};
        vt[5]  = '{0, 1, 5, 4, 12, 1,  4, 1, 0, 1, 0};
        vt[6]  = '{0, 1, 5, 4, 12, 1,  3, 1, 1, 2, 1};
        vt[7]  = '{0, 1, 5, 4, 12, 1,  3, 1, 1, 3, 2};
        vt[8]  = '{0, 1, 5, 4, 12, 1,  3, 1, 1, 4, 3};
        vt[9]  = '{0, 0, 0, 0, 0,  0,  3, 1, 1, 5, 4};
        vt[10] = '{1, 1, 7, 0, 0,  1,  3, 1, 0, 5, 4};
        vt[11] = '{0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 4};
        vt[12] = '{0, 1, 2, 1, 3,  0,  0, 0, 1, 0, 4};
        vt[13] = '{0, 1, 0, 7, 15, 0,  1, 1, 1, 2, 4};
        vt[14] = '{0, 1, 5, 6, 14, 0,  1, 1, 1, 2, 4};
        vt[15] = '{0, 0, 0, 0, 0,  1,  2, 1, 1, 2, 4};
        vt[16] = '{0, 0, 0, 0, 0,  1,  1, 1, 1, 5, 5};
        vt[17] = '{0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 6};

        // Reset, then idle with out_accepted toggling.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 3, 1, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, i[0]);

        for (int i = 0; i < 18; i++) begin
            apply(0, vt[i].f, vt[i].v, vt[i].k, vt[i].a, vt[i].b, vt[i].acc);
            chk($sformatf("vec%0d.count", i), int'(count), vt[i].ec);
            chk($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(vt[i].ev));
            chk($sformatf("vec%0d.in_ready", i), int'(in_ready), int'(vt[i].er));
            chk($sformatf("vec%0d.out_kind", i), int'(out_kind), vt[i].ek);
            chk($sformatf("vec%0d.out_seq", i), int'(out_seq), vt[i].es);
            tick();
        end

        // Seq and pointer wrap: steady push/pop pairs at occupancy one.
        step(0, 0, 1, 3, 5, 9, 0);
        for (int i = 0; i < 40; i++) begin
            apply(0, 0, 1, 1 + (i % 7), i % 8, (i * 3) % 16, 1);
            chk("wrap.count", int'(count), 1);
            tick();
        end
        step(0, 0, 0, 0, 0, 0, 1);

        // Random traffic including flush and mid-operation reset.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) < 7, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 5);
        end

        // Drain and final state.
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 0, 0);
        chk("final.count", int'(count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uop_issue_queue.md
# uop_issue_queue

Buffered front end for the out-of-order core. It accepts micro-ops (kind, operand1, operand2) from the uop source over a valid/ready handshake and holds them in a FIFO of DEPTH entries. It presents them in order to register_file_controller's uop interface, dropping NOPs on entry. Each uop handed off receives a sequence number for trace and debug.

## Interface
- DEPTH, 4: FIFO entries. Power of two, at least 2.
- REGISTER_COUNT, 8: architectural registers. operand1 width is $clog2(REGISTER_COUNT).
- KIND_WIDTH, 3: uop kind width; matches UOP_COMMAND_WIDTH of register_file_controller.
- OPERAND2_WIDTH, 4: operand2 width (register index or immediate).
- SEQ_WIDTH, 4: sequence counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all queued uops.
- in_valid  in  1  source presents a uop.
- in_ready  out  1  queue can take a uop this cycle.
- in_kind  in  KIND_WIDTH  uop kind; 0 = NOP.
- in_operand1  in  $clog2(REGISTER_COUNT)  operand1.
- in_operand2  in  OPERAND2_WIDTH  operand2.
- out_valid  out  1  head uop is presented.
- out_kind / out_operand1 / out_operand2  out  as input  head uop fields.
- out_seq  out  SEQ_WIDTH  sequence number of the head uop.
- out_accepted  in  1  downstream takes the head this cycle.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Push: in_valid & in_ready & in_kind != 0 writes the uop at the tail; tail and count advance.
- NOP drop: in_valid & in_ready & in_kind == 0 completes the handshake, stores nothing, and leaves count unchanged.
- Pop: out_valid & out_accepted advances the head and decrements count. The seq counter increments, modulo 2^SEQ_WIDTH.
  - out_accepted while out_valid=0 is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any occupancy below DEPTH.
- Full (count == DEPTH): in_ready=0. There is no pass-through, even when a pop happens in the same cycle.
- Flush: head, tail and count are cleared at the next edge.
  - Flush overrides any same-cycle push or pop.
  - The seq counter is not reset by flush.
  - in_ready=0 while flush=1.
- Pointers: $clog2(DEPTH) bits, wrapping naturally. Full versus empty is resolved from count, not from the pointers.
- Storage contents are not reset; only the control state is.

## Timing
- Reset values (cycle after rst sampled high): count=0, out_valid=0, out_seq=0, in_ready=1.
- out_kind/out_operand1/out_operand2 read 0 whenever out_valid=0.
- in_ready = !rst & !flush & (count != DEPTH). It is combinational from registered count and the flush/rst inputs.
  - It never depends on in_valid or out_accepted.
- out_valid = (count != 0). The head fields are driven from the storage entry at the head pointer (first-word fall-through).
- Latency: a uop pushed at edge N is visible on out_* after edge N. The minimum from in_valid to out_valid is 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- out_seq of a popped uop equals the number of pops since reset, modulo 2^SEQ_WIDTH.
- Reset mid-operation: the queue empties next cycle regardless of in-flight handshakes. The downstream must ignore out_* during rst.

## Structure
- Shared package uop_pkg holds:
  - KIND_WIDTH and the KIND_NOP constant (0).
  - A packed uop_t typedef {kind, operand1, operand2}, which register_file_controller also uses.
- No sub-module. The storage array, pointers, count and seq counter are held inline; one always block for control and one for storage writes.
- The top level instantiates uop_issue_queue between the uop source and register_file_controller:
  - out_accepted is driven by the controller.
  - out_kind/out_operand1/out_operand2 drive its command_kind/command_operand1/command_operand2.

## Test plan
- Reset, then idle:
  - count=0, out_valid=0, in_ready=1, out_seq=0.
  - out_* stays 0 for 10 cycles with out_accepted toggling.
- Fill: push 4 uops (kind 1..4, op1=i, op2=i+8) with out_accepted=0 -> count=4 and in_ready=0. A fifth in_valid is not accepted. The head shows kind=1, op1=0, op2=8.
- Drain with concurrent push: keep out_accepted=1 and in_valid=1 at full occupancy.
  - Pops proceed in order kind 1,2,3,4 with out_seq 0,1,2,3.
  - A push is accepted only in cycles where count<4.
- NOP drop: push kinds 2,0,5 into an empty queue -> count goes 1, 1, 2. Pops deliver only kinds 2 then 5.
- Flush with push and pop in the same cycle at count=3 -> count=0 and out_valid=0 next cycle. The seq counter keeps its value, and the next pop reports it.
- Seq wrap and pointer wrap: 40 push/pop pairs at count=1 -> out_seq wraps from 15 to 0, data integrity holds across pointer wrap, and count=1 throughout.
